// File: rtl/mul_mdc_job_dispatcher.sv
// ----------------------------------------------------------------------------
// mul_mdc_job_dispatcher
//
// Job queue and sequencer sitting in front of the mul_mdc HWPE control FSM.
// Software contexts push job descriptors (id, length, packed config) into a
// small FIFO. The dispatcher launches them one at a time on the engine, waits
// for the engine's done pulse or a timeout, then retires the job with a
// one-cycle event. This serialises ownership of the accelerator.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              soft clear: flush queue, abort a running job
//   job_valid_i/ready_o  descriptor push handshake
//   job_id_i/len_i/cfg_i descriptor fields
//   timeout_i            max RUN cycles per job, 0 disables the timeout
//   hwpe_start_o         one-cycle start pulse to the engine
//   hwpe_clear_o         one-cycle abort pulse to the engine
//   hwpe_len_o/cfg_o     length/config of the active job (0 while idle)
//   hwpe_busy_i          engine not idle; launch waits while it is high
//   hwpe_done_i          engine done pulse, only honoured in RUN
//   evt_valid_o/id_o/err_o  job-retired event (00 ok, 01 timeout, 10 zero len)
//   pending_o            queued jobs including the active one
//   idle_o               nothing queued and nothing running
// ----------------------------------------------------------------------------
module mul_mdc_job_dispatcher #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LEN_W = 16,
  parameter int CFG_W = 32,
  parameter int TO_W  = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [ID_W-1:0]          job_id_i,
  input  logic [LEN_W-1:0]         job_len_i,
  input  logic [CFG_W-1:0]         job_cfg_i,
  input  logic [TO_W-1:0]          timeout_i,
  output logic                     hwpe_start_o,
  output logic                     hwpe_clear_o,
  output logic [LEN_W-1:0]         hwpe_len_o,
  output logic [CFG_W-1:0]         hwpe_cfg_o,
  input  logic                     hwpe_busy_i,
  input  logic                     hwpe_done_i,
  output logic                     evt_valid_o,
  output logic [ID_W-1:0]          evt_id_o,
  output logic [1:0]               evt_err_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic                     idle_o
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LAUNCH   = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_ZLEN = 2'b10;

  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

  // descriptor storage, no reset needed: validity is tracked by the pointers
  logic [ID_W-1:0]  r_id_mem  [DEPTH];
  logic [LEN_W-1:0] r_len_mem [DEPTH];
  logic [CFG_W-1:0] r_cfg_mem [DEPTH];

  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TO_W-1:0]  r_timer;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_start;
  logic             w_tmo;
  logic [PW:0]      w_count;
  logic [ID_W-1:0]  w_head_id;
  logic [LEN_W-1:0] w_head_len;
  logic [CFG_W-1:0] w_head_cfg;

  // extra pointer bit distinguishes full from empty when the indices match
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_count = r_wptr - r_rptr;

  assign w_head_id  = r_id_mem[r_rptr[PW-1:0]];
  assign w_head_len = r_len_mem[r_rptr[PW-1:0]];
  assign w_head_cfg = r_cfg_mem[r_rptr[PW-1:0]];

  assign job_ready_o = ~w_full & ~clear_i;
  assign w_push      = job_valid_i & job_ready_o;
  assign w_pop       = (r_state == S_COMPLETE) & ~clear_i;

  // ---- next-state logic --------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_start     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (w_head_len == '0) begin
          w_state_nxt = S_COMPLETE;
          w_err_nxt   = ERR_ZLEN;
        end else if (!hwpe_busy_i) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // done has priority over a timeout landing in the same cycle
        if (hwpe_done_i) begin
          w_state_nxt = S_COMPLETE;
          w_err_nxt   = ERR_OK;
        end else if ((timeout_i != '0) && (r_timer == timeout_i - TO_W'(1))) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_COMPLETE;
          w_err_nxt   = ERR_TMO;
        end
      end
      S_COMPLETE: begin
        // decided on the pre-push count so a same-cycle push goes via IDLE
        w_state_nxt = (w_count > ONE) ? S_LAUNCH : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- control registers -------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_err   <= ERR_OK;
      r_timer <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (clear_i) begin
      r_state <= S_IDLE;
      r_err   <= ERR_OK;
      r_timer <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_start) begin
        r_timer <= '0;
      end else if ((r_state == S_RUN) && (r_timer != '1)) begin
        r_timer <= r_timer + TO_W'(1);
      end
      if (w_push) r_wptr <= r_wptr + ONE;
      if (w_pop)  r_rptr <= r_rptr + ONE;
    end
  end

  // ---- descriptor storage ------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id_mem[r_wptr[PW-1:0]]  <= job_id_i;
      r_len_mem[r_wptr[PW-1:0]] <= job_len_i;
      r_cfg_mem[r_wptr[PW-1:0]] <= job_cfg_i;
    end
  end

  // ---- outputs -----------------------------------------------------------
  // head entry stays put from LAUNCH until the COMPLETE pop, so the engine
  // view of the active job is stable without a separate holding register
  assign hwpe_len_o   = (r_state != S_IDLE) ? w_head_len : '0;
  assign hwpe_cfg_o   = (r_state != S_IDLE) ? w_head_cfg : '0;
  assign hwpe_start_o = w_start & ~clear_i;
  assign hwpe_clear_o = (r_state == S_RUN) & (clear_i | w_tmo);
  assign evt_valid_o  = (r_state == S_COMPLETE) & ~clear_i;
  assign evt_id_o     = evt_valid_o ? w_head_id : '0;
  assign evt_err_o    = evt_valid_o ? r_err : 2'b00;
  assign pending_o    = w_count;
  assign idle_o       = (r_state == S_IDLE) & w_empty;

endmodule
